// File: rtl/adder_stim_check.sv
// Stimulus/checker harness for three BITWIDTH-bit adders: drives one vector, waits SETTLE cycles,
// compares every adder against a full-width golden sum and keeps saturating error statistics.
module adder_stim_check #(
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned SETTLE   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] op_a,
   input  logic [BITWIDTH-1:0] op_b,
   input  logic                op_cin,
   output logic [BITWIDTH-1:0] bits_a,
   output logic [BITWIDTH-1:0] bits_b,
   output logic                carry_in,
   input  logic [BITWIDTH-1:0] sum_rca,
   input  logic [BITWIDTH-1:0] sum_prefix,
   input  logic [BITWIDTH-1:0] sum_cla,
   input  logic                cout_rca,
   input  logic                cout_prefix,
   input  logic                cout_cla,
   input  logic                clr_cnt,
   output logic                result_valid,
   output logic [2:0]          fail_mask,
   output logic [15:0]         err_rca,
   output logic [15:0]         err_prefix,
   output logic [15:0]         err_cla,
   output logic [15:0]         vec_cnt
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StWait  = 2'd1;
   localparam logic [1:0] StCheck = 2'd2;

   localparam logic [3:0]  SettleInit = 4'(SETTLE);
   localparam logic [15:0] CntMax     = 16'hFFFF;

   logic [1:0]          state_q, state_d;
   logic [3:0]          settle_q, settle_d;
   logic [BITWIDTH:0]   golden_q, golden_d;
   logic [BITWIDTH-1:0] bits_a_q, bits_a_d;
   logic [BITWIDTH-1:0] bits_b_q, bits_b_d;
   logic                carry_in_q, carry_in_d;
   logic [2:0]          fail_mask_q, fail_mask_d;
   logic                result_valid_q, result_valid_d;
   logic [15:0]         err_rca_q, err_rca_d;
   logic [15:0]         err_prefix_q, err_prefix_d;
   logic [15:0]         err_cla_q, err_cla_d;
   logic [15:0]         vec_cnt_q, vec_cnt_d;

   logic [2:0]          mismatch;
   logic                accept;
   logic                check;

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
      if (en && (cnt != CntMax)) begin
         return cnt + 16'd1;
      end
      return cnt;
   endfunction

   assign accept = (state_q == StIdle) && in_valid;
   assign check  = (state_q == StCheck);

   // Compare with carry-out included so overflow into bit BITWIDTH is checked too.
   assign mismatch[0] = ({cout_rca, sum_rca} != golden_q);
   assign mismatch[1] = ({cout_prefix, sum_prefix} != golden_q);
   assign mismatch[2] = ({cout_cla, sum_cla} != golden_q);

   always_comb begin
      state_d        = state_q;
      settle_d       = settle_q;
      golden_d       = golden_q;
      bits_a_d       = bits_a_q;
      bits_b_d       = bits_b_q;
      carry_in_d     = carry_in_q;
      fail_mask_d    = fail_mask_q;
      result_valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               bits_a_d   = op_a;
               bits_b_d   = op_b;
               carry_in_d = op_cin;
               golden_d   = {1'b0, op_a} + {1'b0, op_b} + {{BITWIDTH{1'b0}}, op_cin};
               settle_d   = SettleInit;
               state_d    = StWait;
            end
         end
         StWait: begin
            settle_d = settle_q - 4'd1;
            if (settle_q <= 4'd1) begin
               settle_d = 4'd0;
               state_d  = StCheck;
            end
         end
         StCheck: begin
            fail_mask_d    = mismatch;
            result_valid_d = 1'b1;
            state_d        = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // A clear coinciding with a check edge suppresses that check's increments.
   always_comb begin
      err_rca_d    = err_rca_q;
      err_prefix_d = err_prefix_q;
      err_cla_d    = err_cla_q;
      vec_cnt_d    = vec_cnt_q;
      if (clr_cnt) begin
         err_rca_d    = 16'd0;
         err_prefix_d = 16'd0;
         err_cla_d    = 16'd0;
         vec_cnt_d    = 16'd0;
      end else if (check) begin
         err_rca_d    = sat_inc(err_rca_q, mismatch[0]);
         err_prefix_d = sat_inc(err_prefix_q, mismatch[1]);
         err_cla_d    = sat_inc(err_cla_q, mismatch[2]);
         vec_cnt_d    = sat_inc(vec_cnt_q, 1'b1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         settle_q       <= 4'd0;
         golden_q       <= '0;
         bits_a_q       <= '0;
         bits_b_q       <= '0;
         carry_in_q     <= 1'b0;
         fail_mask_q    <= 3'b000;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         settle_q       <= settle_d;
         golden_q       <= golden_d;
         bits_a_q       <= bits_a_d;
         bits_b_q       <= bits_b_d;
         carry_in_q     <= carry_in_d;
         fail_mask_q    <= fail_mask_d;
         result_valid_q <= result_valid_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_rca_q    <= 16'd0;
         err_prefix_q <= 16'd0;
         err_cla_q    <= 16'd0;
         vec_cnt_q    <= 16'd0;
      end else begin
         err_rca_q    <= err_rca_d;
         err_prefix_q <= err_prefix_d;
         err_cla_q    <= err_cla_d;
         vec_cnt_q    <= vec_cnt_d;
      end
   end

   assign in_ready     = (state_q == StIdle) && !rst;
   assign bits_a       = bits_a_q;
   assign bits_b       = bits_b_q;
   assign carry_in     = carry_in_q;
   assign result_valid = result_valid_q;
   assign fail_mask    = fail_mask_q;
   assign err_rca      = err_rca_q;
   assign err_prefix   = err_prefix_q;
   assign err_cla      = err_cla_q;
   assign vec_cnt      = vec_cnt_q;

endmodule

// File: tb/tb_adder_stim_check.sv
// Directed bench for adder_stim_check: behavioural adders with per-adder fault masks.
module tb_adder_stim_check;

   localparam int unsigned W      = 8;
   localparam int unsigned SETTLE = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a, op_b;
   logic         op_cin;
   logic [W-1:0] bits_a, bits_b;
   logic         carry_in;
   logic [W-1:0] sum_rca, sum_prefix, sum_cla;
   logic         cout_rca, cout_prefix, cout_cla;
   logic         clr_cnt;
   logic         result_valid;
   logic [2:0]   fail_mask;
   logic [15:0]  err_rca, err_prefix, err_cla, vec_cnt;

   // XOR masks applied to {cout, sum} of each adder to plant faults.
   logic [W:0]   x_rca, x_pre, x_cla;
   logic [W:0]   ideal;

   int           errs   = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   assign ideal                   = {1'b0, bits_a} + {1'b0, bits_b} + {{W{1'b0}}, carry_in};
   assign {cout_rca, sum_rca}       = ideal ^ x_rca;
   assign {cout_prefix, sum_prefix} = ideal ^ x_pre;
   assign {cout_cla, sum_cla}       = ideal ^ x_cla;

   adder_stim_check #(.BITWIDTH(W), .SETTLE(SETTLE)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_cin       (op_cin),
      .bits_a       (bits_a),
      .bits_b       (bits_b),
      .carry_in     (carry_in),
      .sum_rca      (sum_rca),
      .sum_prefix   (sum_prefix),
      .sum_cla      (sum_cla),
      .cout_rca     (cout_rca),
      .cout_prefix  (cout_prefix),
      .cout_cla     (cout_cla),
      .clr_cnt      (clr_cnt),
      .result_valid (result_valid),
      .fail_mask    (fail_mask),
      .err_rca      (err_rca),
      .err_prefix   (err_prefix),
      .err_cla      (err_cla),
      .vec_cnt      (vec_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] e_rca, input logic [15:0] e_pre,
                          input logic [15:0] e_cla, input logic [15:0] e_vec);
      chk({tag, ".err_rca"}, 32'(err_rca), 32'(e_rca));
      chk({tag, ".err_prefix"}, 32'(err_prefix), 32'(e_pre));
      chk({tag, ".err_cla"}, 32'(err_cla), 32'(e_cla));
      chk({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(e_vec));
   endtask

   // Accept a vector, hold in_valid with other operands while busy (must be ignored),
   // and check the result pulse lands exactly SETTLE+1 edges after the accept edge.
   task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [2:0] exp_mask, input logic clr);
      op_a     = a;
      op_b     = b;
      op_cin   = cin;
      in_valid = 1'b1;
      chk({tag, ".ready_before"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      op_a   = ~a;
      op_b   = ~b;
      op_cin = ~cin;
      for (int k = 1; k <= int'(SETTLE) + 1; k++) begin
         chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
         chk({tag, ".busy_rv"}, 32'(result_valid), 32'd0);
         chk({tag, ".bits"}, {15'd0, carry_in, bits_a, bits_b}, {15'd0, cin, a, b});
         if (k == int'(SETTLE) + 1) begin
            in_valid = 1'b0;
            clr_cnt  = clr;
         end
         @(posedge clk); #1;
      end
      clr_cnt = 1'b0;
      chk({tag, ".rv"}, 32'(result_valid), 32'd1);
      chk({tag, ".ready_after"}, 32'(in_ready), 32'd1);
      chk({tag, ".mask"}, 32'(fail_mask), 32'(exp_mask));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      op_a     = '0;
      op_b     = '0;
      op_cin   = 1'b0;
      clr_cnt  = 1'b0;
      x_rca    = '0;
      x_pre    = '0;
      x_cla    = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", 32'(in_ready), 32'd0);
      chk("rst.bits", {15'd0, carry_in, bits_a, bits_b}, 32'd0);
      chk("rst.rv", 32'(result_valid), 32'd0);
      chk("rst.mask", 32'(fail_mask), 32'd0);
      chk_cnt("rst", 16'd0, 16'd0, 16'd0, 16'd0);
      rst = 1'b0;
      #1;
      chk("rel.ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // 0 + 0 + 1: result at E0+3, no failures.
      run_vec("v1", 8'h00, 8'h00, 1'b1, 3'b000, 1'b0);
      chk_cnt("v1", 16'd0, 16'd0, 16'd0, 16'd1);
      @(posedge clk); #1;
      chk("v1.pulse_end", 32'(result_valid), 32'd0);
      chk("v1.mask_hold", 32'(fail_mask), 32'd0);

      // Clear while idle.
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      chk_cnt("clr_idle", 16'd0, 16'd0, 16'd0, 16'd0);

      // Back-to-back carries into bit 8: both golden 0x100.
      run_vec("v2", 8'hFF, 8'h01, 1'b0, 3'b000, 1'b0);
      run_vec("v3", 8'hAA, 8'h55, 1'b1, 3'b000, 1'b0);
      chk_cnt("v3", 16'd0, 16'd0, 16'd0, 16'd2);

      // CLA sum reads 0xFE instead of 0xFF.
      x_cla = 9'h001;
      run_vec("v4", 8'hAA, 8'h55, 1'b0, 3'b100, 1'b0);
      chk_cnt("v4", 16'd0, 16'd0, 16'd1, 16'd3);
      x_cla = '0;

      // Prefix wrong only in carry-out.
      x_pre = 9'h100;
      run_vec("v5", 8'hAA, 8'h55, 1'b0, 3'b010, 1'b0);
      chk_cnt("v5", 16'd0, 16'd1, 16'd1, 16'd4);
      @(posedge clk); #1;
      chk("v5.mask_hold", 32'(fail_mask), 32'd2);
      x_pre = '0;

      // Reset during WAIT aborts the vector.
      op_a     = 8'h01;
      op_b     = 8'h01;
      op_cin   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("abort.accepted", 32'(bits_a), 32'h01);
      rst = 1'b1;
      #1;
      chk("abort.ready", 32'(in_ready), 32'd0);
      chk("abort.bits", {15'd0, carry_in, bits_a, bits_b}, 32'd0);
      chk("abort.mask", 32'(fail_mask), 32'd0);
      chk_cnt("abort", 16'd0, 16'd0, 16'd0, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort.ready_rel", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort.no_rv", 32'(result_valid), 32'd0);
         chk("abort.vec", 32'(vec_cnt), 32'd0);
      end

      // RCA failure counted, then a failing vector with clear on its check edge.
      x_rca = 9'h001;
      run_vec("v6", 8'h12, 8'h34, 1'b0, 3'b001, 1'b0);
      chk_cnt("v6", 16'd1, 16'd0, 16'd0, 16'd1);
      run_vec("v7", 8'h12, 8'h34, 1'b1, 3'b001, 1'b1);
      chk_cnt("v7", 16'd0, 16'd0, 16'd0, 16'd0);

      // Saturation: preload err_rca then fail once more.
      force dut.err_rca_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.err_rca_q;
      chk("sat.preload", 32'(err_rca), 32'hFFFF);
      run_vec("v8", 8'h80, 8'h80, 1'b0, 3'b001, 1'b0);
      chk_cnt("v8", 16'hFFFF, 16'd0, 16'd0, 16'd1);
      x_rca = '0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adder_stim_check.md
ADDER_STIM_CHECK -- requirements
Module: adder_stim_check

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, operand/sum width of the adders under check.
REQ-002 SHALL have parameter SETTLE, default 2, number of wait cycles between driving operands and sampling sums; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  test vector present on op_a/op_b/op_cin.
REQ-006 SHALL have port in_ready  output  1  block can accept a vector.
REQ-007 SHALL have ports op_a, op_b  input  BITWIDTH each  test operands; op_cin  input  1  test carry-in.
REQ-008 SHALL have ports bits_a, bits_b  output  BITWIDTH each; carry_in  output  1  operands driven to all three adders (rca, prefix, cla).
REQ-009 SHALL have ports sum_rca, sum_prefix, sum_cla  input  BITWIDTH each; cout_rca, cout_prefix, cout_cla  input  1 each  adder results.
REQ-010 SHALL have port clr_cnt  input  1  synchronous clear of all counters.
REQ-011 SHALL have port result_valid  output  1  one-cycle pulse, check complete.
REQ-012 SHALL have port fail_mask  output  3  mismatch flags: bit0 rca, bit1 prefix, bit2 cla.
REQ-013 SHALL have ports err_rca, err_prefix, err_cla, vec_cnt  output  16 each  per-adder error counts and total vectors checked.

Function
REQ-014 SHALL implement states IDLE, WAIT, CHECK; in_ready = 1 only in IDLE and not in reset.
REQ-015 SHALL, in IDLE on edge with in_valid=1, register op_a/op_b/op_cin onto bits_a/bits_b/carry_in, register golden = op_a + op_b + op_cin at BITWIDTH+1 bits (no truncation), load settle counter with SETTLE, go to WAIT.
REQ-016 SHALL ignore in_valid outside IDLE; no vector is queued or dropped silently beyond the handshake (in_ready low).
REQ-017 SHALL remain in WAIT for exactly SETTLE cycles, then enter CHECK; bits_a/bits_b/carry_in SHALL stay stable from accept until next accept.
REQ-018 SHALL, on the CHECK edge, compare {cout_x, sum_x} to golden for each adder, register fail_mask, pulse result_valid for exactly one cycle, return to IDLE.
REQ-019 SHALL give latency: accepting edge E0, result_valid/fail_mask updated at edge E0+SETTLE+1; in_ready high again in that same cycle; back-to-back vector accepted at E0+SETTLE+2 at earliest.
REQ-020 SHALL hold fail_mask until the next CHECK edge.
REQ-021 SHALL increment err_x by 1 for each set fail_mask bit and vec_cnt by 1 on every CHECK edge; all counters saturate at 16'hFFFF.
REQ-022 SHALL, when clr_cnt=1, zero all four counters on that edge in any state; clr_cnt coinciding with a CHECK edge: clear wins, no increment; fail_mask/result_valid unaffected.

Reset
REQ-023 SHALL, while rst=1, force state IDLE, in_ready=0, bits_a=bits_b=0, carry_in=0, result_valid=0, fail_mask=000, all counters 0, settle counter 0, golden 0.
REQ-024 SHALL, on rst during WAIT or CHECK, abort the vector with no result_valid pulse and no counter change; after release in_ready=1 on the first cycle.

Verification
REQ-025 SHALL cover: op_a=0x00, op_b=0x00, op_cin=1, correct adders -> result_valid at E0+3 (SETTLE=2), fail_mask=000, vec_cnt=1, errs 0.
REQ-026 SHALL cover: 0xFF+0x01+0, then 0xAA+0x55+1 back-to-back -> golden 0x100 each; fail_mask=000 both; second accept no earlier than E0+4; vec_cnt=2.
REQ-027 SHALL cover: 0xAA+0x55+0 with sum_cla forced 0xFE -> fail_mask=100, err_cla=1, err_rca=err_prefix=0.
REQ-028 SHALL cover: rst asserted in WAIT after accepting 0x01+0x01+0 -> no result_valid, outputs at reset values, in_ready=1 after release.
REQ-029 SHALL cover: clr_cnt on the CHECK edge of a failing vector -> counters all 0, fail_mask reflects failure, result_valid pulses.
REQ-030 SHALL cover: err_rca preloaded to 0xFFFF via 65535 forced-fail vectors (or force) plus one more fail -> err_rca stays 0xFFFF.
